// File: rtl/alu_sched_pkg.sv
// Shared opcodes, widths and FSM state encoding for the alu_sched scheduler.
package alu_sched_pkg;

   localparam int unsigned DW = 4;
   localparam int unsigned RW = 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_NOT = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_GT  = 4'd6;
   localparam logic [3:0] OP_EQ  = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StMul  = 2'd2,
      StResp = 2'd3
   } state_e;

   function automatic logic op_is_legal_alu(input logic [3:0] op);
      return (op <= OP_EQ);
   endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the two requesters, the scheduler and the result consumer.
interface alu_sched_if;
   import alu_sched_pkg::*;

   logic          req0_valid;
   logic          req0_ready;
   logic [3:0]    req0_op;
   logic [DW-1:0] req0_a;
   logic [DW-1:0] req0_b;
   logic          req1_valid;
   logic          req1_ready;
   logic [3:0]    req1_op;
   logic [DW-1:0] req1_a;
   logic [DW-1:0] req1_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_id;
   logic [RW-1:0] rsp_res;
   logic          rsp_cf;
   logic          rsp_of;
   logic          rsp_zf;
   logic          rsp_err;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_res, rsp_cf, rsp_of, rsp_zf, rsp_err
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_res, rsp_cf, rsp_of, rsp_zf, rsp_err
   );

endinterface

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU: add/sub set CF/OF/ZF, logic ops set ZF, compares return 0/1 flagless.
module alu4_core
   import alu_sched_pkg::*;
(
   input  logic [2:0]    op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] res_o,
   output logic          cf_o,
   output logic          of_o,
   output logic          zf_o
);

   always_comb begin
      res_o = '0;
      cf_o  = 1'b0;
      of_o  = 1'b0;
      zf_o  = 1'b0;
      unique case (op_i)
         3'd0: begin
            {cf_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
            of_o = (a_i[3] == b_i[3]) && (res_o[3] != a_i[3]);
            zf_o = (res_o == '0);
         end
         3'd1: begin
            // CF is the carry out of a + ~b + 1, i.e. set when no borrow occurs
            {cf_o, res_o} = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
            of_o = (a_i[3] != b_i[3]) && (res_o[3] != a_i[3]);
            zf_o = (res_o == '0);
         end
         3'd2: begin
            res_o = ~a_i;
            zf_o  = (res_o == '0);
         end
         3'd3: begin
            res_o = a_i & b_i;
            zf_o  = (res_o == '0);
         end
         3'd4: begin
            res_o = a_i | b_i;
            zf_o  = (res_o == '0);
         end
         3'd5: begin
            res_o = a_i ^ b_i;
            zf_o  = (res_o == '0);
         end
         3'd6: res_o = {3'b000, ($signed(a_i) > $signed(b_i))};
         3'd7: res_o = {3'b000, (a_i == b_i)};
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu4_core between two requesters, with shift-add MUL.
// Optional completion counters enabled by defining ALU_SCHED_STATS_EN.
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int unsigned MUL_STEPS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_sched_if.slave   bus,
   output logic         busy,
   output logic [7:0]   stat0_cnt,
   output logic [7:0]   stat1_cnt
);

   state_e        state_q, state_d;
   logic          id_q, id_d;
   logic [3:0]    op_q, op_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] hi_q, hi_d;
   logic [DW-1:0] lo_q, lo_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          rr_q, rr_d;
   logic          won_q, won_d;
   logic          valid_q, valid_d;
   logic [RW-1:0] res_q, res_d;
   logic          cf_q, cf_d;
   logic          of_q, of_d;
   logic          zf_q, zf_d;
   logic          err_q, err_d;

   logic          grant0, grant1, prefer1;
   logic [2:0]    alu_op;
   logic [DW-1:0] alu_b, alu_res;
   logic          alu_cf, alu_of, alu_zf;
   logic          in_idle, in_mul;

   assign in_idle = (state_q == StIdle);
   assign in_mul  = (state_q == StMul);

   // Until the first grant after reset there is no last winner, so req0 takes the first tie.
   assign prefer1 = won_q & ~rr_q;
   assign grant0  = bus.req0_valid & (~bus.req1_valid | ~prefer1);
   assign grant1  = bus.req1_valid & (~bus.req0_valid | prefer1);

   assign bus.req0_ready = in_idle & grant0;
   assign bus.req1_ready = in_idle & grant1;

   assign alu_op = in_mul ? OP_ADD[2:0] : op_q[2:0];
   assign alu_b  = in_mul ? hi_q : b_q;

   alu4_core u_alu (
      .op_i  (alu_op),
      .a_i   (a_q),
      .b_i   (alu_b),
      .res_o (alu_res),
      .cf_o  (alu_cf),
      .of_o  (alu_of),
      .zf_o  (alu_zf)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      won_d   = won_q;
      valid_d = valid_q;
      res_d   = res_q;
      cf_d    = cf_q;
      of_d    = of_q;
      zf_d    = zf_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (grant0 || grant1) begin
               id_d  = grant1;
               op_d  = grant1 ? bus.req1_op : bus.req0_op;
               a_d   = grant1 ? bus.req1_a  : bus.req0_a;
               b_d   = grant1 ? bus.req1_b  : bus.req0_b;
               rr_d  = grant1;
               won_d = 1'b1;
               hi_d  = '0;
               lo_d  = grant1 ? bus.req1_b  : bus.req0_b;
               cnt_d = 2'd0;
               state_d = (op_d == OP_MUL) ? StMul : StExec;
            end
         end
         StExec: begin
            if (op_is_legal_alu(op_q)) begin
               res_d = {{(RW-DW){1'b0}}, alu_res};
               cf_d  = alu_cf;
               of_d  = alu_of;
               zf_d  = alu_zf;
               err_d = 1'b0;
            end else begin
               res_d = '0;
               cf_d  = 1'b0;
               of_d  = 1'b0;
               zf_d  = 1'b0;
               err_d = 1'b1;
            end
            valid_d = 1'b1;
            state_d = StResp;
         end
         StMul: begin
            // Adder carry becomes the new MSB as the partial product shifts right.
            if (lo_q[0]) begin
               {hi_d, lo_d} = {alu_cf, alu_res, lo_q[3:1]};
            end else begin
               {hi_d, lo_d} = {1'b0, hi_q, lo_q[3:1]};
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(MUL_STEPS - 1)) begin
               res_d   = {hi_d, lo_d};
               cf_d    = 1'b0;
               of_d    = (hi_d != '0);
               zf_d    = ({hi_d, lo_d} == '0);
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         id_q    <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= 2'd0;
         rr_q    <= 1'b0;
         won_q   <= 1'b0;
         valid_q <= 1'b0;
         res_q   <= '0;
         cf_q    <= 1'b0;
         of_q    <= 1'b0;
         zf_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         won_q   <= won_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         cf_q    <= cf_d;
         of_q    <= of_d;
         zf_q    <= zf_d;
         err_q   <= err_d;
      end
   end

   assign bus.rsp_valid = valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_res   = res_q;
   assign bus.rsp_cf    = cf_q;
   assign bus.rsp_of    = of_q;
   assign bus.rsp_zf    = zf_q;
   assign bus.rsp_err   = err_q;
   assign busy          = ~in_idle;

`ifdef ALU_SCHED_STATS_EN
   logic [7:0] stat0_q, stat0_d;
   logic [7:0] stat1_q, stat1_d;
   logic       rsp_done;

   assign rsp_done = (state_q == StResp) & bus.rsp_ready;

   always_comb begin
      stat0_d = stat0_q;
      stat1_d = stat1_q;
      if (rsp_done && !id_q && (stat0_q != 8'hFF)) stat0_d = stat0_q + 8'd1;
      if (rsp_done &&  id_q && (stat1_q != 8'hFF)) stat1_d = stat1_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat0_q <= 8'd0;
         stat1_q <= 8'd0;
      end else begin
         stat0_q <= stat0_d;
         stat1_q <= stat1_d;
      end
   end

   assign stat0_cnt = stat0_q;
   assign stat1_cnt = stat1_q;
`else
   assign stat0_cnt = 8'd0;
   assign stat1_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched: ALU ops, MUL, arbitration, stalls, reset, stats.
module tb_alu_sched;

   logic       clk;
   logic       rst_n;
   logic       busy;
   logic [7:0] stat0_cnt;
   logic [7:0] stat1_cnt;
   int         checks;
   int         errors;

   alu_sched_if bus ();

   alu_sched #(.MUL_STEPS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .stat0_cnt (stat0_cnt),
      .stat1_cnt (stat1_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one command on requester id and hold it until accepted (bounded).
   task automatic send(input bit id, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((id && bus.req1_ready) || (!id && bus.req0_ready)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   // Count cycles after the accept edge until rsp_valid is seen; returns at that negedge.
   task automatic wait_rsp(output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_res !== 8'h00 ||
          bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0 ||
          {bus.rsp_cf, bus.rsp_of, bus.rsp_zf} !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: valid=%b busy=%b res=%h id=%b err=%b flags=%b%b%b want all 0",
                  bus.rsp_valid, busy, bus.rsp_res, bus.rsp_id, bus.rsp_err,
                  bus.rsp_cf, bus.rsp_of, bus.rsp_zf);
      end
      checks++;
      if (stat0_cnt !== 8'd0 || stat1_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_stats: got %0d/%0d want 0/0", stat0_cnt, stat1_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit         id;
      logic [3:0] op, a, b;
      logic [7:0] res;
      logic [2:0] flags;  // {cf, of, zf}
   } alu_vec_t;

   task automatic test_alu_ops();
      alu_vec_t vecs[11];
      bit ok;
      int lat;
      vecs[0]  = '{0, 4'd0, 4'd7, 4'd1, 8'h08, 3'b010};
      vecs[1]  = '{1, 4'd1, 4'd4, 4'd4, 8'h00, 3'b101};
      vecs[2]  = '{1, 4'd6, 4'h8, 4'h1, 8'h00, 3'b000};
      vecs[3]  = '{0, 4'd7, 4'd5, 4'd5, 8'h01, 3'b000};
      vecs[4]  = '{1, 4'd5, 4'hA, 4'h5, 8'h0F, 3'b000};
      vecs[5]  = '{0, 4'd2, 4'hF, 4'h0, 8'h00, 3'b001};
      vecs[6]  = '{1, 4'd3, 4'hC, 4'hA, 8'h08, 3'b000};
      vecs[7]  = '{0, 4'd4, 4'h0, 4'h0, 8'h00, 3'b001};
      vecs[8]  = '{1, 4'd0, 4'hF, 4'h1, 8'h00, 3'b101};
      vecs[9]  = '{0, 4'd1, 4'h8, 4'h1, 8'h07, 3'b110};
      vecs[10] = '{1, 4'd6, 4'h1, 4'hF, 8'h01, 3'b000};
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         send(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, ok);
         wait_rsp(lat, ok);
         checks++;
         if (!ok || lat != 2) begin
            errors++;
            $display("FAIL alu_latency[%0d]: got %0d (seen=%b) want 2", i, lat, ok);
         end
         checks++;
         if (bus.rsp_res !== vecs[i].res ||
             {bus.rsp_cf, bus.rsp_of, bus.rsp_zf} !== vecs[i].flags ||
             bus.rsp_id !== vecs[i].id || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL alu_result[%0d]: got res=%h cf/of/zf=%b%b%b id=%b err=%b want res=%h flags=%b id=%b err=0",
                     i, bus.rsp_res, bus.rsp_cf, bus.rsp_of, bus.rsp_zf, bus.rsp_id, bus.rsp_err,
                     vecs[i].res, vecs[i].flags, vecs[i].id);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL alu_release[%0d]: got valid=%b busy=%b want 0/0", i, bus.rsp_valid, busy);
         end
      end
   endtask

   task automatic test_mul();
      logic [3:0] ta[3], tb[3];
      logic [7:0] tres[3];
      logic [1:0] tfl[3];  // {of, zf}
      bit ids[3];
      bit ok;
      int lat;
      ta[0] = 4'hF; tb[0] = 4'hF; tres[0] = 8'hE1; tfl[0] = 2'b10; ids[0] = 0;
      ta[1] = 4'h0; tb[1] = 4'h9; tres[1] = 8'h00; tfl[1] = 2'b01; ids[1] = 0;
      ta[2] = 4'h3; tb[2] = 4'h5; tres[2] = 8'h0F; tfl[2] = 2'b00; ids[2] = 1;
      for (int i = 0; i < 3; i++) begin
         send(ids[i], 4'd8, ta[i], tb[i], ok);
         wait_rsp(lat, ok);
         checks++;
         if (!ok || lat != 5) begin
            errors++;
            $display("FAIL mul_latency[%0d]: got %0d (seen=%b) want 5", i, lat, ok);
         end
         checks++;
         if (bus.rsp_res !== tres[i] || bus.rsp_cf !== 1'b0 ||
             {bus.rsp_of, bus.rsp_zf} !== tfl[i] || bus.rsp_err !== 1'b0 ||
             bus.rsp_id !== ids[i]) begin
            errors++;
            $display("FAIL mul_result[%0d]: got res=%h cf=%b of/zf=%b%b err=%b id=%b want res=%h cf=0 of/zf=%b err=0 id=%b",
                     i, bus.rsp_res, bus.rsp_cf, bus.rsp_of, bus.rsp_zf, bus.rsp_err, bus.rsp_id,
                     tres[i], tfl[i], ids[i]);
         end
         @(posedge clk);
      end
   endtask

   task automatic test_illegal();
      bit ok;
      int lat;
      send(1'b1, 4'd12, 4'h3, 4'h4, ok);
      wait_rsp(lat, ok);
      checks++;
      if (!ok || lat != 2 || bus.rsp_err !== 1'b1 || bus.rsp_res !== 8'h00 ||
          {bus.rsp_cf, bus.rsp_of, bus.rsp_zf} !== 3'b000) begin
         errors++;
         $display("FAIL illegal_op: got lat=%0d err=%b res=%h flags=%b%b%b want lat=2 err=1 res=00 flags=000",
                  lat, bus.rsp_err, bus.rsp_res, bus.rsp_cf, bus.rsp_of, bus.rsp_zf);
      end
      @(posedge clk);
   endtask

   task automatic test_back_to_back();
      int rem[2];
      bit grants[8];
      int g, rn;
      bit gid;
      rem[0] = 4; rem[1] = 4; g = 0; rn = 0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_op = 4'd0; bus.req1_a = 4'd2; bus.req1_b = 4'd2;
      for (int cyc = 0; cyc < 100 && rn < 8; cyc++) begin
         #1;
         if (bus.req0_ready && bus.req1_ready) begin
            checks++;
            errors++;
            $display("FAIL b2b_dual_ready: got both ready want at most one");
         end
         if (bus.rsp_valid) begin
            checks++;
            if (bus.rsp_id !== grants[rn]) begin
               errors++;
               $display("FAIL b2b_rsp_id[%0d]: got %b want %b", rn, bus.rsp_id, grants[rn]);
            end
            rn++;
         end
         if (bus.req0_ready || bus.req1_ready) begin
            gid = bus.req1_ready;
            checks++;
            if (gid !== g[0]) begin
               errors++;
               $display("FAIL b2b_grant[%0d]: got %b want %b", g, gid, g[0]);
            end
            if (g < 8) grants[g] = gid;
            g++;
            rem[gid] = rem[gid] - 1;
         end
         @(posedge clk);
         #1;
         if (rem[0] <= 0) bus.req0_valid = 1'b0;
         if (rem[1] <= 0) bus.req1_valid = 1'b0;
         @(negedge clk);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      checks++;
      if (g != 8 || rn != 8) begin
         errors++;
         $display("FAIL b2b_count: got grants=%0d responses=%0d want 8/8", g, rn);
      end
   endtask

   task automatic test_stall();
      bit ok;
      int lat;
      bus.rsp_ready = 1'b0;
      send(1'b0, 4'd0, 4'd2, 4'd3, ok);
      wait_rsp(lat, ok);
      bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_op = 4'd0; bus.req1_a = 4'd1; bus.req1_b = 4'd1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 8'h05 || bus.rsp_id !== 1'b0 ||
             {bus.rsp_cf, bus.rsp_of, bus.rsp_zf} !== 3'b000 || busy !== 1'b1 ||
             bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got valid=%b res=%h id=%b busy=%b rdy=%b%b want 1/05/0/1/00",
                     i, bus.rsp_valid, bus.rsp_res, bus.rsp_id, busy,
                     bus.req0_ready, bus.req1_ready);
         end
         if (i < 5) @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      // Back in IDLE with both valid: req0 won last, so req1 is offered the grant.
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req1_ready !== 1'b1 ||
          bus.req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got valid=%b busy=%b rdy0=%b rdy1=%b want 0/0/0/1",
                  bus.rsp_valid, busy, bus.req0_ready, bus.req1_ready);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_accept: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid_mul();
      bit ok;
      bit seen;
      int lat;
      send(1'b0, 4'd8, 4'hF, 4'hF, ok);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_res !== 8'h00 ||
          bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0 ||
          {bus.rsp_cf, bus.rsp_of, bus.rsp_zf} !== 3'b000 ||
          stat0_cnt !== 8'd0 || stat1_cnt !== 8'd0) begin
         errors++;
         $display("FAIL mid_mul_reset: got valid=%b busy=%b res=%h stats=%0d/%0d want all 0",
                  bus.rsp_valid, busy, bus.rsp_res, stat0_cnt, stat1_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.rsp_valid || busy) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_mul_discard: got response/busy after reset want none");
      end
      // First tie after reset goes to req0.
      bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
      bus.req1_valid = 1'b1; bus.req1_op = 4'd0; bus.req1_a = 4'd3; bus.req1_b = 4'd4;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL first_tie: got rdy0=%b rdy1=%b want 1/0", bus.req0_ready, bus.req1_ready);
      end
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_rsp(lat, ok);
      checks++;
      if (!ok || bus.rsp_res !== 8'h03 || bus.rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL first_tie_rsp: got seen=%b res=%h id=%b want 1/03/0", ok, bus.rsp_res, bus.rsp_id);
      end
      @(posedge clk);
   endtask

   task automatic test_stats();
      bit ok;
      int lat;
      int timeouts;
      logic [7:0] exp0_start, exp0_end, exp1_end;
`ifdef ALU_SCHED_STATS_EN
      exp0_start = 8'd1; exp0_end = 8'd255; exp1_end = 8'd1;
`else
      exp0_start = 8'd0; exp0_end = 8'd0; exp1_end = 8'd0;
`endif
      #1;
      checks++;
      if (stat0_cnt !== exp0_start || stat1_cnt !== 8'd0) begin
         errors++;
         $display("FAIL stats_start: got %0d/%0d want %0d/0", stat0_cnt, stat1_cnt, exp0_start);
      end
      timeouts = 0;
      for (int i = 0; i < 300; i++) begin
         send(1'b0, 4'd5, i[3:0], 4'h3, ok);
         wait_rsp(lat, ok);
         if (!ok) timeouts++;
         @(posedge clk);
      end
      send(1'b1, 4'd3, 4'h3, 4'h1, ok);
      wait_rsp(lat, ok);
      if (!ok) timeouts++;
      @(posedge clk);
      #1;
      checks++;
      if (timeouts != 0 || stat0_cnt !== exp0_end || stat1_cnt !== exp1_end) begin
         errors++;
         $display("FAIL stats_saturate: got %0d/%0d timeouts=%0d want %0d/%0d timeouts=0",
                  stat0_cnt, stat1_cnt, timeouts, exp0_end, exp1_end);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp_ready = 1'b1;
      test_reset();
      test_alu_ops();
      test_mul();
      test_illegal();
      test_back_to_back();
      test_stall();
      test_reset_mid_mul();
      test_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
